// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_arbiter
// Purpose  : Two-master Wishbone arbiter in front of one shared RAM slave.
//            Alternating priority on contention, bus lock while the granted
//            master holds cyc, per-beat ack timeout with a one-cycle err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  // master 1
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  // shared slave
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  // arbitration status
  output logic [1:0]              grant_o
);

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t           state;
  logic [1:0]       grant;
  logic             last_grant;   // index of the master served most recently
  logic [CNT_W-1:0] tmo_cnt;
  logic             m0_err;
  logic             m1_err;
  logic             stall;
  logic             expire;
  logic [CNT_W-1:0] cnt_next;

  // Route the granted master straight onto the slave bus; idle bus is all zero.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (grant[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (grant[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  // Slave responses only reach the granted master; ack in IDLE goes nowhere.
  assign m0_ack_o = s_ack_i & grant[0];
  assign m1_ack_o = s_ack_i & grant[1];
  assign m0_dat_o = grant[0] ? s_dat_i : '0;
  assign m1_dat_o = grant[1] ? s_dat_i : '0;
  assign m0_err_o = m0_err;
  assign m1_err_o = m1_err;
  assign grant_o  = grant;

  // A beat is stalled while strobed and unacknowledged; ack beats the timeout.
  assign stall = s_cyc_o & s_stb_o & ~s_ack_i;

  // Next timeout count and expiry flag for the current stalled beat.
  always_comb begin
    expire   = 1'b0;
    cnt_next = '0;
    if ((TIMEOUT != 0) && stall) begin
      if (tmo_cnt == CNT_LAST) begin
        expire = 1'b1;
      end else begin
        cnt_next = tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Arbitration FSM with registered grant, timeout counter and err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      tmo_cnt    <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
            state <= GRANT0;
            grant <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= GRANT1;
            grant <= 2'b10;
          end
        end
        GRANT0: begin
          if (!m0_cyc_i) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b0;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= cnt_next;
            m0_err  <= expire;
          end
        end
        GRANT1: begin
          if (!m1_cyc_i) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= cnt_next;
            m1_err  <= expire;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= 2'b00;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
